// File: rtl/uart_rx_edge_sampler.sv
// Oversampling front-end of the UART receiver: per-bit edge counter, per-frame
// bit counter and a three-point mid-bit majority sampler with a done strobe.
module uart_rx_edge_sampler #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  counter_enable,
   input  logic                  data_sample_en,
   output logic [PRESCALE_W-1:0] edge_count,
   output logic [3:0]            bit_count,
   output logic                  sampled_bit,
   output logic                  sample_done
);

   localparam logic [PRESCALE_W-1:0] P_MIN   = PRESCALE_W'(6);
   localparam logic [3:0]            BIT_MAX = 4'd15;

   logic [PRESCALE_W-1:0] p_q, p_d;
   logic [PRESCALE_W-1:0] edge_q, edge_d;
   logic [3:0]            bit_q, bit_d;
   logic                  s0_q, s0_d;
   logic                  s1_q, s1_d;
   logic                  v0_q, v0_d;
   logic                  v1_q, v1_d;
   logic                  sampled_q, sampled_d;
   logic                  done_q, done_d;

   logic [PRESCALE_W-1:0] prescale_even;
   logic [PRESCALE_W-1:0] prescale_legal;
   logic [PRESCALE_W-1:0] half;
   logic [PRESCALE_W-1:0] last_edge;
   logic                  at_wrap;
   logic                  at_cap0;
   logic                  at_cap1;
   logic                  at_cap2;
   logic                  capture_en;
   logic                  majority;

   // Odd ratios are rounded down and tiny ones raised so the H-1..H+2 window fits in a bit.
   assign prescale_even  = {Prescale[PRESCALE_W-1:1], 1'b0};
   assign prescale_legal = (prescale_even < P_MIN) ? P_MIN : prescale_even;

   assign half       = {1'b0, p_q[PRESCALE_W-1:1]};
   assign last_edge  = p_q - PRESCALE_W'(1);
   assign at_wrap    = (edge_q == last_edge);
   assign at_cap0    = (edge_q == half - PRESCALE_W'(1));
   assign at_cap1    = (edge_q == half);
   assign at_cap2    = (edge_q == half + PRESCALE_W'(1));
   assign capture_en = counter_enable & data_sample_en;
   assign majority   = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);

   always_comb begin
      // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
      p_d       = p_q;
      edge_d    = edge_q;
      bit_d     = bit_q;
      s0_d      = s0_q;
      s1_d      = s1_q;
      v0_d      = v0_q;
      v1_d      = v1_q;
      sampled_d = sampled_q;
      done_d    = 1'b0;

      if (!counter_enable) begin
         p_d    = prescale_legal;
         edge_d = '0;
         bit_d  = '0;
         s0_d   = 1'b0;
         s1_d   = 1'b0;
         v0_d   = 1'b0;
         v1_d   = 1'b0;
      end else begin
         if (at_wrap) begin
            edge_d = '0;
            if (bit_q != BIT_MAX) begin
               bit_d = bit_q + 4'd1;
            end
         end else begin
            edge_d = edge_q + PRESCALE_W'(1);
         end

         // v0/v1 remember that the earlier captures of this bit were actually taken.
         if (at_cap0) begin
            s0_d = RX_IN;
            v0_d = data_sample_en;
         end
         if (at_cap1) begin
            s1_d = RX_IN;
            v1_d = v0_q & data_sample_en;
         end
         if (at_cap2 && capture_en && v1_q) begin
            sampled_d = majority;
            done_d    = 1'b1;
         end
         if (at_cap2) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q       <= P_MIN;
         edge_q    <= '0;
         bit_q     <= '0;
         s0_q      <= 1'b0;
         s1_q      <= 1'b0;
         v0_q      <= 1'b0;
         v1_q      <= 1'b0;
         sampled_q <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         p_q       <= p_d;
         edge_q    <= edge_d;
         bit_q     <= bit_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         v0_q      <= v0_d;
         v1_q      <= v1_d;
         sampled_q <= sampled_d;
         done_q    <= done_d;
      end
   end

   assign edge_count  = edge_q;
   assign bit_count   = bit_q;
   assign sampled_bit = sampled_q;
   assign sample_done = done_q;

endmodule

// File: doc/uart_rx_edge_sampler.md
# uart_rx_edge_sampler

- Oversampling front-end of the UART receiver; sits directly upstream of the RX frame FSM.
- Counts oversampling edges within each bit and bits within each frame, both on the FSM's counter enable.
- Majority-votes three mid-bit samples of `RX_IN` into one recovered bit.
- Reports a one-cycle strobe when the bit is ready; the FSM, deserializer and parity/start/stop checkers consume it.

## Interface

Parameters:
- `PRESCALE_W`, default 6: width of `Prescale` and `edge_count`.

Ports:
- `clk`, input, 1: sole clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `RX_IN`, input, 1: serial line, already synchronous to `clk`. The synchronizer lives outside this block.
- `Prescale`, input, `PRESCALE_W`: oversampling ratio in clk cycles per bit.
- `counter_enable`, input, 1: from the FSM; runs the counters.
- `data_sample_en`, input, 1: from the FSM; enables mid-bit sampling.
- `edge_count`, output, `PRESCALE_W`: cycle index within the current bit.
- `bit_count`, output, 4: completed bits since `counter_enable` rose; saturates at 15.
- `sampled_bit`, output, 1: last majority-voted bit.
- `sample_done`, output, 1: one-cycle strobe; `sampled_bit` was updated this cycle.

## Operation

**Effective prescale `P`**
- Latched into an internal register on every clock edge where `counter_enable` is 0.
- Held constant while `counter_enable` is 1. `Prescale` changes mid-frame are ignored.
- Legalised at latch time: bit 0 is forced to 0, then values below 6 become 6.
- Legal effective range: even values from 6 to 2^PRESCALE_W−2.

**Counters**
- `counter_enable` = 0: `edge_count` and `bit_count` load 0 on the next edge.
- `counter_enable` = 1 and `edge_count` < P−1: `edge_count` increments.
- `counter_enable` = 1 and `edge_count` == P−1:
  - `edge_count` loads 0.
  - `bit_count` increments, saturating at 15.
- `edge_count` therefore equals n during the n-th cycle of `counter_enable` high, counting from 0.

**Sampler**
- Three capture points, with H = P/2: `edge_count` == H−1, H and H+1.
- A capture happens only when `counter_enable` and `data_sample_en` are both 1.
- Samples s0 and s1 are registered at H−1 and H.
- At the H+1 edge, the majority of (s0, s1, `RX_IN`) is registered into `sampled_bit`, and `sample_done` is set for one cycle.
- Result: `sampled_bit` and `sample_done` are visible in the cycle where `edge_count` == H+2. This matches the FSM's stop-check threshold.
- If either enable is 0 at any capture point, that bit produces no `sample_done`, and `sampled_bit` holds its value.
- s0 and s1 clear when `counter_enable` is 0.
- `sampled_bit` holds between strobes. It is not cleared by `counter_enable` going low.

**Reset (`rst` = 1, asynchronous)**
- `edge_count` = 0, `bit_count` = 0.
- `sampled_bit` = 1, the idle line level.
- `sample_done` = 0, s0 = s1 = 0.
- Effective P = 6.
- Reset mid-frame abandons the frame. No strobe is emitted after `rst` deasserts until a full new capture sequence completes.

## Timing

- All outputs are registered. No combinational path from inputs to outputs.
- Latency from the third capture (`edge_count` == H+1) to `sample_done`/`sampled_bit`: 1 cycle.
- Per bit: exactly one `sample_done` when both enables stay high across H−1 through H+1; otherwise zero.
- `bit_count` increments in the cycle after `edge_count` shows P−1. It is valid one cycle before the next bit's capture window.
- `counter_enable` falling mid-bit: counters read 0 in the following cycle, and any pending capture is discarded.
- `counter_enable` rising: first cycle shows `edge_count` = 0, using the P latched on the preceding edge.
- Simultaneous wrap and `counter_enable` fall: the clear wins; `bit_count` = 0.

## Test plan

- **Basic counting and sampling.** P = 8, both enables held high for 16 cycles, `RX_IN` = 0.
  - `edge_count` runs 0..7, 0..7.
  - `bit_count` = 1 from cycle 8 and 2 from cycle 16.
  - `sample_done` fires in cycles 6 and 14 with `sampled_bit` = 0.
- **Glitch rejection.** P = 16, `RX_IN` = 1 except 0 only at `edge_count` = 8 → `sampled_bit` = 1 at `edge_count` = 10. With `RX_IN` = 0 at `edge_count` 7 and 9 → `sampled_bit` = 0.
- **Prescale handling.**
  - `Prescale` changed from 8 to 16 at `edge_count` = 3 → the current frame keeps wrapping at 7.
  - `Prescale` = 5 latched → effective P = 6; wraps at 5, strobe at `edge_count` = 5.
- **Enable drop mid-bit.** P = 8, `counter_enable` drops while `edge_count` = 4 → next cycle `edge_count` = 0 and `bit_count` = 0, no `sample_done`, `sampled_bit` unchanged. `data_sample_en` = 0 for a whole bit → counters run, no strobe.
- **Saturation.** Enables high for 20 bits at P = 6 → `bit_count` stops at 15.
- **Asynchronous reset mid-bit.** `rst` pulsed between edges at `edge_count` = 5, P = 8 → outputs return to reset values immediately. After release: no strobe until a full H−1..H+1 window completes.
